// File: rtl/pwm_freq_divider_pkg.sv
// Shared constants for the frequency-select decoder, the period divider
// and its bench: divisor width, reset/minimum divisor and the decoder table.
package pwm_freq_divider_pkg;

  localparam int DIV_W     = 7;
  localparam int DIV_RESET = 41;
  localparam int DIV_MIN   = 2;

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DIV_SEL0 = div_t'(41);
  localparam div_t DIV_SEL1 = div_t'(25);
  localparam div_t DIV_SEL2 = div_t'(16);
  localparam div_t DIV_SEL3 = div_t'(12);
  localparam div_t DIV_SEL4 = div_t'(10);
  localparam div_t DIV_SEL5 = div_t'(8);
  localparam div_t DIV_SEL6 = div_t'(7);
  localparam div_t DIV_SEL7 = div_t'(6);

  function automatic div_t decoder_div(input logic [2:0] sel);
    div_t d;
    d = DIV_SEL0;
    unique case (sel)
      3'd0: d = DIV_SEL0;
      3'd1: d = DIV_SEL1;
      3'd2: d = DIV_SEL2;
      3'd3: d = DIV_SEL3;
      3'd4: d = DIV_SEL4;
      3'd5: d = DIV_SEL5;
      3'd6: d = DIV_SEL6;
      3'd7: d = DIV_SEL7;
      default: d = DIV_SEL0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_freq_divider.sv
// Period counter for the DPWM carrier: tick per period and ~50% clk_div.
// Optional DIV_UPDATE_PULSE_EN adds a div_updated pulse on divisor change.
import pwm_freq_divider_pkg::*;

module pwm_freq_divider #(
  parameter int WIDTH     = DIV_W,
  parameter int RESET_DIV = DIV_RESET,
  parameter int MIN_DIV   = DIV_MIN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] paradiv,
  output logic             tick,
  output logic             clk_div,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active
`ifdef DIV_UPDATE_PULSE_EN
  ,
  output logic             div_updated
`endif
);

  localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] LP_MIN = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] w_eff;
  logic [WIDTH-1:0] w_half;
  logic             w_last;
  logic             w_load;

  assign w_eff  = (paradiv < LP_MIN) ? LP_MIN : paradiv;
  assign w_half = r_div >> 1;
  assign w_last = (r_count == (r_div - LP_ONE));
  assign w_load = !enable || w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_div   <= LP_RST;
    end else if (!enable) begin
      r_count <= '0;
      r_div   <= w_eff;
    end else if (w_last) begin
      r_count <= '0;
      r_div   <= w_eff;
    end else begin
      r_count <= r_count + LP_ONE;
    end
  end

  // reset_n gating keeps clk_div low during reset even with enable high
  assign tick    = reset_n && enable && w_last;
  assign clk_div = reset_n && enable && (r_count < w_half);

  assign count      = r_count;
  assign div_active = r_div;

`ifdef DIV_UPDATE_PULSE_EN
  logic r_upd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_load && (w_eff != r_div);
    end
  end

  assign div_updated = r_upd;
`endif

endmodule

// File: tb/tb_pwm_freq_divider.sv
// Directed bench for pwm_freq_divider with a per-cycle scoreboard.
// Checks div_updated only when DIV_UPDATE_PULSE_EN is defined.
module tb_pwm_freq_divider;
  import pwm_freq_divider_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [6:0] paradiv;
  logic       tick;
  logic       clk_div;
  logic [6:0] count;
  logic [6:0] div_active;
`ifdef DIV_UPDATE_PULSE_EN
  logic       div_updated;
`endif

  pwm_freq_divider dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .paradiv    (paradiv),
    .tick       (tick),
    .clk_div    (clk_div),
    .count      (count),
    .div_active (div_active)
`ifdef DIV_UPDATE_PULSE_EN
    ,
    .div_updated(div_updated)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int dv;
    int tk;
    int cd;
    int up;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int m_count;
  int m_div;
  int m_upd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_div   = DIV_RESET;
    m_upd   = 0;
  endtask

  task automatic model_edge();
    int eff;
    eff = (int'(paradiv) < DIV_MIN) ? DIV_MIN : int'(paradiv);
    if (!enable || m_count == m_div - 1) begin
      m_upd   = (eff != m_div) ? 1 : 0;
      m_count = 0;
      m_div   = eff;
    end else begin
      m_upd   = 0;
      m_count = m_count + 1;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e.cnt = m_count;
    e.dv  = m_div;
    e.tk  = (reset_n && enable && m_count == m_div - 1) ? 1 : 0;
    e.cd  = (reset_n && enable && m_count < m_div / 2) ? 1 : 0;
    e.up  = m_upd;
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    sb.push_back(predict());
    e = sb.pop_front();
    chk("sb_count", count, e.cnt);
    chk("sb_div", div_active, e.dv);
    chk("sb_tick", tick, e.tk);
    chk("sb_clk_div", clk_div, e.cd);
`ifdef DIV_UPDATE_PULSE_EN
    chk("sb_div_updated", div_updated, e.up);
`endif
  endtask

  task automatic run_until_count(input int target);
    for (int i = 0; i < 200; i++) begin
      if (int'(count) == target) break;
      cyc();
    end
    chk("reach_count", count, target);
  endtask

  task automatic run_until_div(input int target);
    for (int i = 0; i < 200; i++) begin
      if (int'(div_active) == target) break;
      cyc();
    end
    chk("reach_div", div_active, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] cd12;
    logic [11:0] tk12;
    logic [13:0] cd14;
    logic [13:0] tk14;
    logic [5:0]  cd6;
    logic [5:0]  tk6;
    int          n;
    int          ups;

    reset_n = 1'b0;
    enable  = 1'b0;
    paradiv = decoder_div(3'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_div", div_active, 41);
    chk("rst_tick", tick, 0);
    chk("rst_clk_div", clk_div, 0);
    reset_n = 1'b1;
    repeat (2) cyc();
    chk("idle_div41", div_active, 41);

    paradiv = decoder_div(3'd7);
    cyc();
    enable = 1'b1;
    #1;
    chk("start6_count", count, 0);
    chk("start6_div", div_active, 6);
    for (int i = 0; i < 12; i++) begin
      cd12[11-i] = clk_div;
      tk12[11-i] = tick;
      cyc();
    end
    chk("n6_clk_div_pat", cd12, 12'b111000111000);
    chk("n6_tick_pat", tk12, 12'b000001000001);

    paradiv = decoder_div(3'd6);
    repeat (6) cyc();
    chk("n7_loaded", div_active, 7);
    chk("n7_count0", count, 0);
    for (int i = 0; i < 14; i++) begin
      cd14[13-i] = clk_div;
      tk14[13-i] = tick;
      cyc();
    end
    chk("n7_clk_div_pat", cd14, 14'b11100001110000);
    chk("n7_tick_pat", tk14, 14'b00000010000001);

    paradiv = decoder_div(3'd0);
    repeat (7) cyc();
    chk("n41_loaded", div_active, 41);
    run_until_count(10);
    paradiv = decoder_div(3'd5);
    for (int i = 0; i < 100; i++) begin
      if (tick) break;
      cyc();
    end
    chk("chg_tick_count", count, 40);
    chk("chg_old_div", div_active, 41);
    cyc();
    chk("chg_new_count", count, 0);
    chk("chg_new_div", div_active, 8);
    for (int i = 0; i < 20; i++) begin
      if (tick) break;
      cyc();
    end
    chk("n8_tick_count", count, 7);

    paradiv = 7'd0;
    cyc();
    chk("clamp0_div", div_active, 2);
    for (int i = 0; i < 6; i++) begin
      cd6[5-i] = clk_div;
      tk6[5-i] = tick;
      cyc();
    end
    chk("clamp_clk_div_pat", cd6, 6'b101010);
    chk("clamp_tick_pat", tk6, 6'b010101);
    paradiv = 7'd1;
    repeat (4) cyc();
    chk("clamp1_div", div_active, 2);

    paradiv = decoder_div(3'd0);
    run_until_div(41);
    run_until_count(17);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_count", count, 0);
    chk("arst_div", div_active, 41);
    chk("arst_tick", tick, 0);
    chk("arst_clk_div", clk_div, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    paradiv = decoder_div(3'd3);
    run_until_div(12);
    run_until_count(5);
    enable = 1'b0;
    #1;
    chk("drop_tick", tick, 0);
    chk("drop_clk_div", clk_div, 0);
    cyc();
    chk("drop_count", count, 0);
    paradiv = decoder_div(3'd2);
    ups = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
`ifdef DIV_UPDATE_PULSE_EN
      if (div_updated) ups++;
`endif
    end
`ifdef DIV_UPDATE_PULSE_EN
    chk("upd_pulses", ups, 1);
`endif
    enable = 1'b1;
    #1;
    chk("restart_count", count, 0);
    chk("restart_div", div_active, 16);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (tick) break;
      cyc();
      n++;
    end
    chk("restart_tick_edges", n, 15);
    chk("restart_tick_cnt", count, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
